// File: rtl/ascensor_ctrl_n.sv
// ascensor_ctrl_n: N-floor elevator controller with SCAN direction choice.
// Latches hall/car calls, times per-floor travel and door dwell on the en tick.
// Optional feature macro: ASCENSOR_EMERG_EN adds the emerg freeze input.
module ascensor_ctrl_n #(
    parameter int unsigned N_PISOS  = 4,
    parameter int unsigned W_PISO   = 2,
    parameter int unsigned T_VIAJE  = 4,
    parameter int unsigned T_PUERTA = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [N_PISOS-1:0]  llamada,
    input  logic [N_PISOS-1:0]  destino,
`ifdef ASCENSOR_EMERG_EN
    input  logic                emerg,
`endif
    output logic [W_PISO-1:0]   piso,
    output logic                sube,
    output logic                baja,
    output logic                puerta_abierta,
    output logic [N_PISOS-1:0]  pendientes
);

    localparam int unsigned T_MAX = (T_VIAJE > T_PUERTA) ? T_VIAJE : T_PUERTA;
    localparam int unsigned W_T   = $clog2(T_MAX + 1);
    localparam logic [W_PISO-1:0] PISO_TOP = W_PISO'(N_PISOS - 1);

    typedef enum logic [1:0] {REPOSO, MOVIENDO, PUERTA} estado_t;

    estado_t              r_estado, w_estado_n;
    logic [W_PISO-1:0]    r_piso, w_piso_n, w_piso_sig;
    logic                 r_dir_up, w_dir_n, w_dir_sig;
    logic [W_T-1:0]       r_timer, w_timer_n;
    logic [N_PISOS-1:0]   r_pend, w_req, w_clr;
    logic                 r_sube, r_baja, r_puerta;
    logic                 w_emerg, w_go, w_reabre;
    logic                 w_aqui, w_delante, w_detras, w_en_borde;
    logic                 w_sig_aqui, w_sig_delante, w_fin_viaje, w_fin_puerta;

    // Pending bit for floor f
    function automatic logic bit_en(input logic [N_PISOS-1:0] v, input logic [W_PISO-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(N_PISOS); i++)
            if (W_PISO'(i) == f) r = v[i];
        return r;
    endfunction

    // Any pending request strictly above floor f
    function automatic logic hay_arriba(input logic [N_PISOS-1:0] v, input logic [W_PISO-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(N_PISOS); i++)
            if (W_PISO'(i) > f && v[i]) r = 1'b1;
        return r;
    endfunction

    // Any pending request strictly below floor f
    function automatic logic hay_abajo(input logic [N_PISOS-1:0] v, input logic [W_PISO-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(N_PISOS); i++)
            if (W_PISO'(i) < f && v[i]) r = 1'b1;
        return r;
    endfunction

`ifdef ASCENSOR_EMERG_EN
    assign w_emerg = emerg;
`else
    assign w_emerg = 1'b0;
`endif

    assign w_go          = en & ~w_emerg;
    assign w_req         = llamada | destino;
    assign w_aqui        = bit_en(r_pend, r_piso);
    assign w_delante     = r_dir_up ? hay_arriba(r_pend, r_piso) : hay_abajo(r_pend, r_piso);
    assign w_detras      = r_dir_up ? hay_abajo(r_pend, r_piso) : hay_arriba(r_pend, r_piso);
    assign w_fin_viaje   = (r_timer == W_T'(T_VIAJE - 1));
    assign w_fin_puerta  = (r_timer == W_T'(T_PUERTA - 1));
    assign w_en_borde    = r_dir_up ? (r_piso == PISO_TOP) : (r_piso == '0);
    assign w_piso_sig    = w_en_borde ? r_piso
                         : (r_dir_up ? r_piso + W_PISO'(1) : r_piso - W_PISO'(1));
    assign w_dir_sig     = (w_piso_sig == '0) ? 1'b1
                         : ((w_piso_sig == PISO_TOP) ? 1'b0 : r_dir_up);
    assign w_sig_aqui    = bit_en(r_pend, w_piso_sig);
    assign w_sig_delante = w_dir_sig ? hay_arriba(r_pend, w_piso_sig) : hay_abajo(r_pend, w_piso_sig);
    // A call for the floor whose door is open keeps the door open
    assign w_reabre      = (r_estado == PUERTA) & bit_en(w_req, r_piso) & ~w_emerg;

    // Next-state logic: SCAN decision, travel and door timers
    always_comb begin
        w_estado_n = r_estado;
        w_piso_n   = r_piso;
        w_dir_n    = r_dir_up;
        w_timer_n  = r_timer;
        if (w_reabre) begin
            w_timer_n = '0;
        end else if (w_go) begin
            case (r_estado)
                REPOSO: begin
                    w_timer_n = '0;
                    if (w_aqui) begin
                        w_estado_n = PUERTA;
                    end else if (w_delante) begin
                        w_estado_n = MOVIENDO;
                    end else if (w_detras) begin
                        w_estado_n = MOVIENDO;
                        w_dir_n    = ~r_dir_up;
                    end
                end
                MOVIENDO: begin
                    if (w_fin_viaje) begin
                        w_timer_n = '0;
                        w_piso_n  = w_piso_sig;
                        w_dir_n   = w_dir_sig;
                        if (w_sig_aqui)         w_estado_n = PUERTA;
                        else if (w_sig_delante) w_estado_n = MOVIENDO;
                        else                    w_estado_n = REPOSO;
                    end else begin
                        w_timer_n = r_timer + W_T'(1);
                    end
                end
                PUERTA: begin
                    if (w_fin_puerta) begin
                        w_timer_n  = '0;
                        w_estado_n = REPOSO;
                    end else begin
                        w_timer_n = r_timer + W_T'(1);
                    end
                end
                default: begin
                    w_estado_n = REPOSO;
                    w_timer_n  = '0;
                end
            endcase
        end
    end

    // Request of the floor being served with the door open is dropped
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < int'(N_PISOS); i++)
            if (w_estado_n == PUERTA && W_PISO'(i) == w_piso_n) w_clr[i] = 1'b1;
    end

    // Request latch, runs every clock regardless of the time-base tick
    always_ff @(posedge clk) begin
        if (rst)          r_pend <= '0;
        else if (w_emerg) r_pend <= '0;
        else              r_pend <= (r_pend | w_req) & ~w_clr;
    end

    // State register with outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= REPOSO;
            r_piso   <= '0;
            r_dir_up <= 1'b1;
            r_timer  <= '0;
            r_sube   <= 1'b0;
            r_baja   <= 1'b0;
            r_puerta <= 1'b0;
        end else begin
            r_estado <= w_estado_n;
            r_piso   <= w_piso_n;
            r_dir_up <= w_dir_n;
            r_timer  <= w_timer_n;
            r_sube   <= (w_estado_n == MOVIENDO) &  w_dir_n & ~w_emerg;
            r_baja   <= (w_estado_n == MOVIENDO) & ~w_dir_n & ~w_emerg;
            r_puerta <= (w_estado_n == PUERTA);
        end
    end

    assign piso           = r_piso;
    assign sube           = r_sube;
    assign baja           = r_baja;
    assign puerta_abierta = r_puerta;
    assign pendientes     = r_pend;

endmodule

// File: tb/tb_ascensor_ctrl_n.sv
// Bench for ascensor_ctrl_n: directed scenarios plus random traffic against a floor-level model.
module tb_ascensor_ctrl_n;

    localparam int NP = 4;
    localparam int TV = 2;
    localparam int TP = 3;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [3:0] llamada, destino;
    logic       emerg;
    logic [1:0] piso;
    logic       sube, baja, puerta_abierta;
    logic [3:0] pendientes;

    int n_cmp = 0;
    int n_err = 0;

    // Model: floor number, activity (0 idle, 1 travelling, 2 door open), direction, tick count
    int m_floor, m_mode, m_cnt;
    bit m_up, m_frz;
    bit m_req [NP];

    ascensor_ctrl_n #(.N_PISOS(4), .W_PISO(2), .T_VIAJE(TV), .T_PUERTA(TP)) dut (
        .clk(clk), .rst(rst), .en(en), .llamada(llamada), .destino(destino),
`ifdef ASCENSOR_EMERG_EN
        .emerg(emerg),
`endif
        .piso(piso), .sube(sube), .baja(baja), .puerta_abierta(puerta_abierta),
        .pendientes(pendientes)
    );

    always #5 clk = ~clk;

    function automatic bit m_any(input int lo, input int hi);
        bit r = 0;
        for (int i = 0; i < NP; i++) if (i >= lo && i <= hi && m_req[i]) r = 1;
        return r;
    endfunction

    function automatic bit m_ahead(input int f, input bit up);
        return up ? m_any(f + 1, NP - 1) : m_any(0, f - 1);
    endfunction

    task automatic model_step(input bit r, input bit e, input bit em, input logic [3:0] q);
        bit nq [NP];
        bit was_door;
        int f0;
        if (r) begin
            m_floor = 0; m_mode = 0; m_cnt = 0; m_up = 1; m_frz = 0;
            for (int i = 0; i < NP; i++) m_req[i] = 0;
            return;
        end
        if (em) begin
            for (int i = 0; i < NP; i++) m_req[i] = 0;
            m_frz = 1;
            return;
        end
        m_frz = 0;
        for (int i = 0; i < NP; i++) nq[i] = m_req[i] | q[i];
        was_door = (m_mode == 2);
        f0 = m_floor;
        if (e) begin
            if (m_mode == 0) begin
                m_cnt = 0;
                if (m_req[f0]) m_mode = 2;
                else if (m_ahead(f0, m_up)) m_mode = 1;
                else if (m_any(0, NP - 1)) begin m_up = !m_up; m_mode = 1; end
            end else if (m_mode == 1) begin
                m_cnt++;
                if (m_cnt == TV) begin
                    m_cnt = 0;
                    m_floor = m_up ? m_floor + 1 : m_floor - 1;
                    if (m_floor == 0) m_up = 1;
                    if (m_floor == NP - 1) m_up = 0;
                    if (m_req[m_floor]) m_mode = 2;
                    else if (!m_ahead(m_floor, m_up)) m_mode = 0;
                end
            end else begin
                m_cnt++;
                if (m_cnt == TP) begin m_cnt = 0; m_mode = 0; end
            end
        end
        if (was_door && q[f0]) begin m_mode = 2; m_cnt = 0; end
        if (m_mode == 2) nq[m_floor] = 0;
        for (int i = 0; i < NP; i++) m_req[i] = nq[i];
    endtask

    function automatic logic [8:0] exp_vec();
        logic [3:0] p;
        for (int i = 0; i < NP; i++) p[i] = m_req[i];
        return {2'(m_floor), m_mode == 1 && m_up && !m_frz, m_mode == 1 && !m_up && !m_frz,
                m_mode == 2, p};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {piso, sube, baja, puerta_abierta, pendientes};
    endfunction

    task automatic step(input logic [3:0] l, input logic [3:0] d, input logic e, input logic r,
                        input logic em);
        @(negedge clk);
        llamada = l; destino = d; en = e; rst = r; emerg = em;
        @(posedge clk);
        model_step(r, e, em, l | d);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(4'b0110, 4'b0001, 1, 1, 0);
            n_cmp++;
            if (dut_vec() !== 9'b0) begin
                n_err++;
                $display("FAIL reset_values cyc%0d: got %b want %b", c, dut_vec(), 9'b0);
            end
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_model cyc%0d: got %b want %b", c, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single_call();
        int n_up, n_door;
        n_up = 0; n_door = 0;
        step(0, 0, 1, 1, 0);
        step(4'b1000, 0, 1, 0, 0);
        n_cmp++;
        if (pendientes !== 4'b1000) begin
            n_err++;
            $display("FAIL call_latch: got %b want %b", pendientes, 4'b1000);
        end
        for (int c = 0; c < 20; c++) begin
            step(0, 0, 1, 0, 0);
            n_up += int'(sube); n_door += int'(puerta_abierta);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL single_call cyc%0d: got %b want %b", c, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (n_up !== 6 || n_door !== 3 || piso !== 2'd3 || pendientes !== 4'b0 || puerta_abierta !== 1'b0) begin
            n_err++;
            $display("FAIL single_call_summary: up=%0d door=%0d piso=%0d pend=%b want 6 3 3 0000",
                     n_up, n_door, piso, pendientes);
        end
    endtask

    task automatic test_intermediate_stop();
        int doors[$];
        bit done, prev;
        logic [3:0] d;
        done = 0; prev = 0;
        step(0, 0, 1, 1, 0);
        step(4'b1000, 0, 1, 0, 0);
        for (int c = 0; c < 40; c++) begin
            d = 4'b0;
            if (!done && sube && piso == 2'd0) begin d = 4'b0010; done = 1; end
            step(0, d, 1, 0, 0);
            if (puerta_abierta && !prev) doors.push_back(int'(piso));
            prev = puerta_abierta;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL intermediate cyc%0d: got %b want %b", c, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (doors.size() != 2 || doors[0] != 1 || doors[1] != 3) begin
            n_err++;
            $display("FAIL intermediate_order: got %0d stops %p want stops at 1 then 3", doors.size(), doors);
        end
    endtask

    task automatic test_scan();
        int doors[$];
        bit prev, saw_down;
        prev = 0; saw_down = 0;
        step(0, 0, 1, 1, 0);
        step(4'b0100, 0, 1, 0, 0);
        for (int c = 0; c < 15; c++) step(0, 0, 1, 0, 0);
        n_cmp++;
        if (piso !== 2'd2 || puerta_abierta !== 1'b0 || sube !== 1'b0) begin
            n_err++;
            $display("FAIL scan_setup: piso=%0d door=%b sube=%b want 2 0 0", piso, puerta_abierta, sube);
        end
        step(4'b1001, 0, 1, 0, 0);
        for (int c = 0; c < 40; c++) begin
            step(0, 0, 1, 0, 0);
            if (puerta_abierta && !prev) doors.push_back(int'(piso));
            prev = puerta_abierta;
            if (baja) saw_down = 1;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL scan cyc%0d: got %b want %b", c, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (doors.size() != 2 || doors[0] != 3 || doors[1] != 0 || !saw_down) begin
            n_err++;
            $display("FAIL scan_order: got %0d stops %p down=%0d want 3 then 0 with down", doors.size(), doors, saw_down);
        end
    endtask

    task automatic test_door_restart_and_hold();
        int n_open, p0;
        bit got;
        got = 0;
        step(0, 0, 1, 1, 0);
        step(4'b0100, 0, 1, 0, 0);
        for (int c = 0; c < 20 && !got; c++) begin
            step(0, 0, 1, 0, 0);
            if (puerta_abierta) got = 1;
        end
        n_cmp++;
        if (!got || piso !== 2'd2) begin
            n_err++;
            $display("FAIL door_reach: got door=%b piso=%0d want 1 2", puerta_abierta, piso);
        end
        step(0, 0, 1, 0, 0);
        step(4'b0100, 0, 1, 0, 0);
        n_cmp++;
        if (pendientes[2] !== 1'b0 || puerta_abierta !== 1'b1 || dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL door_absorb: got %b want %b (pend[2]=0, door=1)", dut_vec(), exp_vec());
        end
        n_open = 1;
        for (int c = 0; c < 6; c++) begin
            step(0, 0, 1, 0, 0);
            n_open += int'(puerta_abierta);
        end
        n_cmp++;
        if (n_open != 3) begin
            n_err++;
            $display("FAIL door_restart: got %0d open ticks want 3", n_open);
        end
        // hold travel with en low
        step(0, 0, 1, 1, 0);
        step(4'b1000, 0, 1, 0, 0);
        for (int c = 0; c < 3; c++) step(0, 0, 1, 0, 0);
        p0 = int'(piso);
        n_cmp++;
        if (p0 != 1 || sube !== 1'b1) begin
            n_err++;
            $display("FAIL hold_setup: got piso=%0d sube=%b want 1 1", p0, sube);
        end
        for (int c = 0; c < 5; c++) begin
            step(0, (c == 2) ? 4'b0001 : 4'b0000, 0, 0, 0);
            n_cmp++;
            if (int'(piso) != p0 || sube !== 1'b1 || dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL hold_en0 cyc%0d: got %b want %b", c, dut_vec(), exp_vec());
            end
        end
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        n_cmp++;
        if (piso !== 2'd2 || pendientes !== 4'b1001) begin
            n_err++;
            $display("FAIL hold_resume: got piso=%0d pend=%b want 2 1001", piso, pendientes);
        end
    endtask

    task automatic test_reset_mid_travel();
        bit got;
        got = 0;
        step(0, 0, 1, 1, 0);
        step(4'b1000, 0, 1, 0, 0);
        for (int c = 0; c < 10 && !got; c++) begin
            step(0, 0, 1, 0, 0);
            if (piso == 2'd1 && sube) got = 1;
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL midreset_reach: got piso=%0d sube=%b want 1 1", piso, sube);
        end
        step(4'b0100, 4'b0010, 1, 1, 0);
        n_cmp++;
        if (dut_vec() !== 9'b0 || dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL midreset: got %b want %b", dut_vec(), 9'b0);
        end
    endtask

`ifdef ASCENSOR_EMERG_EN
    task automatic test_emerg();
        bit got;
        got = 0;
        step(0, 0, 1, 1, 0);
        step(4'b1000, 0, 1, 0, 0);
        for (int c = 0; c < 10 && !got; c++) begin
            step(0, 0, 1, 0, 0);
            if (piso == 2'd1 && sube) got = 1;
        end
        for (int c = 0; c < 4; c++) begin
            step(4'b0001, 0, 1, 0, 1);
            n_cmp++;
            if (sube !== 1'b0 || piso !== 2'd1 || pendientes !== 4'b0 || dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL emerg cyc%0d: got %b want %b", c, dut_vec(), exp_vec());
            end
        end
        for (int c = 0; c < 12; c++) begin
            step(0, 0, 1, 0, 0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL emerg_release cyc%0d: got %b want %b", c, dut_vec(), exp_vec());
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] l, d;
        logic e, r;
        step(0, 0, 1, 1, 0);
        for (int c = 0; c < 1500; c++) begin
            l = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            d = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            e = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 299) == 0);
            step(l, d, e, r, 0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc%0d: got %b want %b", c, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; llamada = '0; destino = '0; emerg = 1'b0;
        m_floor = 0; m_mode = 0; m_cnt = 0; m_up = 1; m_frz = 0;
        for (int i = 0; i < NP; i++) m_req[i] = 0;
        test_reset();
        test_single_call();
        test_intermediate_stop();
        test_scan();
        test_door_restart_and_hold();
        test_reset_mid_travel();
`ifdef ASCENSOR_EMERG_EN
        test_emerg();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
